// File: rtl/cross_engine_arbiter.sv
// rtl/cross_engine_arbiter.sv - round-robin arbiter with bounded lock feeding a pipelined signed 2-D cross-product engine
//
// Purpose
//   Shares one cross-product engine between NREQ requesters. The grant is
//   round-robin from a pointer. A requester can hold the grant for up to
//   LOCK_MAX consecutive accepts by asserting req_lock. Each accepted op
//   {x0,y0,x1,y1,x2,y2} produces (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0). The
//   result is tagged with its requester and appears after a fixed latency:
//   an op accepted at edge N is visible on the outputs after edge N+2.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  per-requester operand set pending
//   req_lock   per-requester request to keep the grant on the next cycle
//   req_op     per-requester {x0,y0,x1,y1,x2,y2}, x0 in MSBs, requester i at slice i
//   req_ready  one-hot grant; op accepted when valid & ready
//   rsp_valid  one-hot response tag
//   rsp_cross  signed cross product, 2*CW+3 bits
//   rsp_neg    sign of rsp_cross
//   busy       an op is in flight in stage 1 or stage 2
module cross_engine_arbiter #(
    parameter int NREQ     = 2,
    parameter int CW       = 10,
    parameter int LOCK_MAX = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ*6*CW-1:0]  req_op,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*CW+2:0]       rsp_cross,
    output logic                  rsp_neg,
    output logic                  busy
);
    localparam int TW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(LOCK_MAX + 1);
    localparam int DW   = CW + 1;
    localparam int PW   = 2 * CW + 2;
    localparam int RW   = 2 * CW + 3;
    localparam int OPW  = 6 * CW;

    function automatic logic [TW-1:0] add_mod(input logic [TW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return TW'(s);
    endfunction

    // Arbitration state
    logic [TW-1:0]   ptr_q, ptr_d;
    logic            lock_active_q, lock_active_d;
    logic [TW-1:0]   lock_owner_q, lock_owner_d;
    logic [CNTW-1:0] lock_cnt_q, lock_cnt_d;

    // Pipeline state
    logic                 s1_valid_q, s1_valid_d;
    logic [TW-1:0]        s1_tag_q, s1_tag_d;
    logic signed [DW-1:0] s1_dx1_q, s1_dx1_d;
    logic signed [DW-1:0] s1_dy2_q, s1_dy2_d;
    logic signed [DW-1:0] s1_dx2_q, s1_dx2_d;
    logic signed [DW-1:0] s1_dy1_q, s1_dy1_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [TW-1:0]        s2_tag_q, s2_tag_d;
    logic signed [PW-1:0] s2_p1_q, s2_p1_d;
    logic signed [PW-1:0] s2_p2_q, s2_p2_d;

    logic                 out_valid_q, out_valid_d;
    logic [TW-1:0]        out_tag_q, out_tag_d;
    logic signed [RW-1:0] out_cross_q, out_cross_d;

    // Grant selection: depends only on valids, pointer and lock state
    logic          grant_any;
    logic [TW-1:0] grant_idx;
    logic [TW-1:0] cand;
    logic          accept;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (lock_active_q && req_valid[lock_owner_q]) begin
            grant_any = 1'b1;
            grant_idx = lock_owner_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = add_mod(ptr_q, k);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign accept = reset && grant_any;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Lock and pointer update. A lost valid on the owner releases the lock
    // first, so an accept by another requester in the same cycle is handled
    // as an ordinary unlocked accept (and may arm a new lock).
    logic lock_eff;

    always_comb begin
        ptr_d         = ptr_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        lock_eff      = lock_active_q;

        if (lock_active_q && !req_valid[lock_owner_q]) begin
            lock_active_d = 1'b0;
            lock_cnt_d    = '0;
            ptr_d         = add_mod(lock_owner_q, 1);
            lock_eff      = 1'b0;
        end

        if (accept) begin
            if (lock_eff) begin
                // Only the owner can be granted while the lock is effective.
                if (req_lock[grant_idx] && (int'(lock_cnt_q) + 1 < LOCK_MAX)) begin
                    lock_cnt_d = lock_cnt_q + CNTW'(1);
                end else begin
                    lock_active_d = 1'b0;
                    lock_cnt_d    = '0;
                    ptr_d         = add_mod(grant_idx, 1);
                end
            end else begin
                ptr_d = add_mod(grant_idx, 1);
                // First locked accept counts as one grant; a bound of 1
                // means the lock never survives past its own accept.
                if (req_lock[grant_idx] && (LOCK_MAX > 1)) begin
                    lock_active_d = 1'b1;
                    lock_owner_d  = grant_idx;
                    lock_cnt_d    = CNTW'(1);
                end
            end
        end
    end

    // Operand extraction for the granted requester
    logic [OPW-1:0]       op_sel;
    logic [CW-1:0]        x0, y0, x1, y1, x2, y2;
    logic signed [DW-1:0] dx1, dy2, dx2, dy1;

    assign op_sel = req_op[int'(grant_idx)*OPW +: OPW];
    assign x0     = op_sel[5*CW +: CW];
    assign y0     = op_sel[4*CW +: CW];
    assign x1     = op_sel[3*CW +: CW];
    assign y1     = op_sel[2*CW +: CW];
    assign x2     = op_sel[1*CW +: CW];
    assign y2     = op_sel[0*CW +: CW];

    // Zero-extend to CW+1 so the differences are exact signed values.
    assign dx1 = $signed({1'b0, x1}) - $signed({1'b0, x0});
    assign dy2 = $signed({1'b0, y2}) - $signed({1'b0, y0});
    assign dx2 = $signed({1'b0, x2}) - $signed({1'b0, x0});
    assign dy1 = $signed({1'b0, y1}) - $signed({1'b0, y0});

    // Datapath stages; data registers only load when their stage is valid.
    always_comb begin
        s1_valid_d = accept;
        s1_tag_d   = s1_tag_q;
        s1_dx1_d   = s1_dx1_q;
        s1_dy2_d   = s1_dy2_q;
        s1_dx2_d   = s1_dx2_q;
        s1_dy1_d   = s1_dy1_q;
        if (accept) begin
            s1_tag_d = grant_idx;
            s1_dx1_d = dx1;
            s1_dy2_d = dy2;
            s1_dx2_d = dx2;
            s1_dy1_d = dy1;
        end

        s2_valid_d = s1_valid_q;
        s2_tag_d   = s2_tag_q;
        s2_p1_d    = s2_p1_q;
        s2_p2_d    = s2_p2_q;
        if (s1_valid_q) begin
            s2_tag_d = s1_tag_q;
            s2_p1_d  = PW'(s1_dx1_q) * PW'(s1_dy2_q);
            s2_p2_d  = PW'(s1_dx2_q) * PW'(s1_dy1_q);
        end

        out_valid_d = s2_valid_q;
        out_tag_d   = out_tag_q;
        out_cross_d = out_cross_q;
        if (s2_valid_q) begin
            out_tag_d   = s2_tag_q;
            out_cross_d = RW'(s2_p1_q) - RW'(s2_p2_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q         <= '0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
            lock_cnt_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_tag_q      <= '0;
            s1_dx1_q      <= '0;
            s1_dy2_q      <= '0;
            s1_dx2_q      <= '0;
            s1_dy1_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_tag_q      <= '0;
            s2_p1_q       <= '0;
            s2_p2_q       <= '0;
            out_valid_q   <= 1'b0;
            out_tag_q     <= '0;
            out_cross_q   <= '0;
        end else begin
            ptr_q         <= ptr_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_tag_q      <= s1_tag_d;
            s1_dx1_q      <= s1_dx1_d;
            s1_dy2_q      <= s1_dy2_d;
            s1_dx2_q      <= s1_dx2_d;
            s1_dy1_q      <= s1_dy1_d;
            s2_valid_q    <= s2_valid_d;
            s2_tag_q      <= s2_tag_d;
            s2_p1_q       <= s2_p1_d;
            s2_p2_q       <= s2_p2_d;
            out_valid_q   <= out_valid_d;
            out_tag_q     <= out_tag_d;
            out_cross_q   <= out_cross_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (out_valid_q) begin
            rsp_valid[out_tag_q] = 1'b1;
        end
    end

    assign rsp_cross = out_cross_q;
    assign rsp_neg   = out_cross_q[RW-1];
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_cross_engine_arbiter.sv
// tb/tb_cross_engine_arbiter.sv - self-checking bench for cross_engine_arbiter
module tb_cross_engine_arbiter;
    localparam int NREQ     = 2;
    localparam int CW       = 10;
    localparam int LOCK_MAX = 6;
    localparam int OPW      = 6 * CW;
    localparam int MAXC     = 4096;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*OPW-1:0]  req_op;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [2*CW+2:0]      rsp_cross;
    logic                 rsp_neg;
    logic                 busy;

    cross_engine_arbiter #(.NREQ(NREQ), .CW(CW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_op    (req_op),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_cross (rsp_cross),
        .rsp_neg   (rsp_neg),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side stimulus state
    logic            reset_drv;
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] lk;
    int              ops [NREQ][6];

    // Reference model: arbitration rules plus a cycle-indexed log of accepts
    int m_ptr, m_lock, m_owner, m_cnt;
    bit acc_v     [MAXC];
    int acc_tag   [MAXC];
    int acc_cross [MAXC];
    int cyc, rst_cyc, last_g;
    int last_cross [NREQ];
    int last_neg   [NREQ];

    int n_checks, n_fail;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int ref_cross(input int i);
        int x0, y0, x1, y1, x2, y2;
        x0 = ops[i][0]; y0 = ops[i][1];
        x1 = ops[i][2]; y1 = ops[i][3];
        x2 = ops[i][4]; y2 = ops[i][5];
        return (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
    endfunction

    function automatic int model_grant();
        if (m_lock != 0 && vld[m_owner]) return m_owner;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_owner = 0; m_cnt = 0;
    endtask

    task automatic model_release(input int g);
        m_lock = 0;
        m_cnt  = 0;
        m_ptr  = (g + 1) % NREQ;
    endtask

    task automatic model_update(input int g);
        if (m_lock != 0 && !vld[m_owner]) model_release(m_owner);
        if (g >= 0) begin
            if (m_lock != 0) begin
                if (lk[g]) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_MAX) model_release(g);
                end else begin
                    model_release(g);
                end
            end else begin
                m_ptr = (g + 1) % NREQ;
                if (lk[g]) begin
                    m_owner = g;
                    m_cnt   = 1;
                    m_lock  = 1;
                    if (m_cnt >= LOCK_MAX) model_release(g);
                end
            end
        end
    endtask

    function automatic bit live(input int c);
        return c >= 0 && c < MAXC && c > rst_cyc && acc_v[c];
    endfunction

    task automatic apply_inputs();
        reset     = reset_drv;
        req_valid = vld;
        req_lock  = lk;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 6; k++)
                req_op[i*OPW + (5-k)*CW +: CW] = CW'(ops[i][k]);
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c,
                          input int d, input int e, input int f);
        ops[i][0] = a; ops[i][1] = b; ops[i][2] = c;
        ops[i][3] = d; ops[i][4] = e; ops[i][5] = f;
    endtask

    task automatic new_op(input int i);
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0:       ops[i][k] = 0;
                1:       ops[i][k] = 1023;
                default: ops[i][k] = int'($urandom_range(0, 1023));
            endcase
        end
    endtask

    // One clock cycle: drive, check at the falling edge, update the model.
    task automatic cycle();
        int g, src, got_x;
        logic [NREQ-1:0] exp_ready, exp_rv;
        logic exp_busy;
        apply_inputs();
        @(negedge clk);
        g = reset_drv ? model_grant() : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_ready);
        src    = cyc - 3;
        exp_rv = '0;
        if (live(src)) exp_rv[acc_tag[src]] = 1'b1;
        exp_busy = live(cyc - 1) || live(cyc - 2);
        check_eq("rsp_valid", rsp_valid, exp_rv);
        check_eq("busy", busy, exp_busy);
        if (live(src)) begin
            got_x = int'($signed(rsp_cross));
            check_eq("rsp_cross", got_x, acc_cross[src]);
            check_eq("rsp_neg", rsp_neg, acc_cross[src] < 0);
            check_eq("rsp_range", (got_x <= 2093058 && got_x >= -2093058), 1);
            last_cross[acc_tag[src]] = got_x;
            last_neg[acc_tag[src]]   = int'(rsp_neg);
        end
        if (g >= 0) begin
            acc_v[cyc]     = 1'b1;
            acc_tag[cyc]   = g;
            acc_cross[cyc] = ref_cross(g);
        end
        if (!reset_drv) begin
            model_reset();
            rst_cyc = cyc;
        end else begin
            model_update(g);
        end
        last_g = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int basic_val, sign_val, prev;
        int lock_exp [8];
        n_checks = 0;
        n_fail   = 0;
        lock_exp = '{0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 0, 0, 0, 0, 0, 0);
            last_cross[i] = 32'h7fffffff;
            last_neg[i]   = -1;
        end

        // Initial reset with both requesters asserting valid
        reset_drv = 1'b0;
        vld       = '1;
        lk        = '0;
        cyc       = 0;
        apply_inputs();
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_in_reset", req_ready, 0);
        @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_cross", rsp_cross, 0);
        check_eq("rst_rsp_neg", rsp_neg, 0);
        reset_drv = 1'b1;
        vld       = '0;
        rst_cyc   = -1;
        model_reset();

        // Basic op on requester 0
        set_op(0, 0, 0, 4, 0, 0, 3);
        vld = 2'b01;
        cycle();
        check_eq("basic_grant", last_g, 0);
        vld = '0;
        repeat (4) cycle();
        check_eq("basic_cross", last_cross[0], 12);
        check_eq("basic_neg", last_neg[0], 0);
        basic_val = last_cross[0];

        // Swapped vertices give the negated result
        last_cross[0] = 32'h7fffffff;
        set_op(0, 0, 0, 0, 3, 4, 0);
        vld = 2'b01;
        cycle();
        vld = '0;
        repeat (4) cycle();
        check_eq("sign_cross", last_cross[0], -12);
        check_eq("sign_neg", last_neg[0], 1);
        sign_val = last_cross[0];
        check_eq("sign_sum", basic_val + sign_val, 0);

        // Fairness at full throughput
        vld = '1;
        lk  = '0;
        new_op(0);
        new_op(1);
        prev = -1;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (prev >= 0) check_eq("fair_alt", last_g, 1 - prev);
            prev = last_g;
            new_op(last_g);
        end
        vld = '0;
        repeat (4) cycle();

        // Lock bound after a reset so the pointer starts at requester 0
        reset_drv = 1'b0;
        cycle();
        reset_drv = 1'b1;
        vld = '1;
        lk  = 2'b01;
        new_op(0);
        new_op(1);
        for (int n = 0; n < 8; n++) begin
            cycle();
            check_eq("lock_seq", last_g, lock_exp[n]);
            new_op(last_g);
        end
        vld = '0;
        lk  = '0;
        repeat (4) cycle();

        // Extreme coordinates
        last_cross[0] = 32'h7fffffff;
        last_cross[1] = 32'h7fffffff;
        set_op(0, 1023, 1023, 0, 1023, 1023, 0);
        vld = 2'b01;
        cycle();
        set_op(1, 0, 0, 1023, 0, 0, 1023);
        vld = 2'b10;
        cycle();
        vld = '0;
        repeat (4) cycle();
        check_eq("ext_cross0", last_cross[0], 1046529);
        check_eq("ext_cross1", last_cross[1], 1046529);

        // Reset with two ops in flight
        vld = '1;
        new_op(0);
        new_op(1);
        cycle();
        new_op(last_g);
        cycle();
        new_op(last_g);
        reset_drv = 1'b0;
        cycle();
        reset_drv = 1'b1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        cycle();
        check_eq("post_rst_grant", last_g, 0);
        vld = '0;
        repeat (4) cycle();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && $urandom_range(0, 3) != 0) begin
                    vld[i] = 1'b1;
                    lk[i]  = 1'($urandom_range(0, 1));
                    new_op(i);
                end
            end
            reset_drv = ($urandom_range(0, 199) != 0);
            cycle();
            if (last_g >= 0) vld[last_g] = 1'b0;
            reset_drv = 1'b1;
        end
        vld = '0;
        lk  = '0;
        repeat (5) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
